// File: rtl/regfile_operand_fetch_if.sv
// Request, operand and write-back channels between a fetch client and the operand-fetch sequencer.
interface regfile_operand_fetch_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs1;
    logic [ADDR_W-1:0] req_rs2;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    modport master (
        output req_valid, req_rs1, req_rs2, wb_valid, wb_addr, wb_data, op_ready,
        input  req_ready, op_valid, op_a, op_b
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, wb_valid, wb_addr, wb_data, op_ready,
        output req_ready, op_valid, op_a, op_b
    );
endinterface

// File: rtl/regfile_operand_fetch.sv
// Two-operand fetch sequencer in front of a single-read-port register file, with
// write-back pass-through and same-cycle write forwarding into the captured operands.
module regfile_operand_fetch #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_operand_fetch_if.slave fetch,
    output logic                   rf_en,
    output logic                   rf_read,
    output logic [ADDR_W-1:0]      rf_selout,
    input  logic [DATA_W-1:0]      rf_out,
    output logic                   rf_write,
    output logic [ADDR_W-1:0]      rf_selin,
    output logic [DATA_W-1:0]      rf_inp
);
    typedef enum logic [1:0] {IDLE = 2'd0, RD_A = 2'd1, RD_B = 2'd2, HOLD = 2'd3} state_t;

    state_t            state, state_nxt;
    logic              accept, wb_hit, rd_zero;
    logic [DATA_W-1:0] cap_data;
    logic              req_ready_q, req_ready_d;
    logic              op_valid_q, op_valid_d;
    logic              rf_read_q, rf_read_d;
    logic              rf_en_q;
    logic [ADDR_W-1:0] rf_selout_q, rf_selout_d;
    logic [ADDR_W-1:0] rs2_q, rs2_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;

    assign accept   = (state == IDLE) && req_ready_q && fetch.req_valid;
    // rf_selout always names the register being read during RD_A/RD_B
    assign wb_hit   = fetch.wb_valid && (fetch.wb_addr == rf_selout_q);
    assign rd_zero  = ZERO_REG && (rf_selout_q == '0);
    assign cap_data = rd_zero ? '0 : (wb_hit ? fetch.wb_data : rf_out);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RD_A;
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = HOLD;
            HOLD:    if (fetch.op_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        req_ready_d = (state_nxt == IDLE);
        op_valid_d  = (state_nxt == HOLD);
        rf_read_d   = (state_nxt == RD_A) || (state_nxt == RD_B);
        rf_selout_d = rf_selout_q;
        rs2_d       = rs2_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        case (state)
            IDLE: if (accept) begin
                rf_selout_d = fetch.req_rs1;
                rs2_d       = fetch.req_rs2;
            end
            RD_A: begin
                op_a_d      = cap_data;
                rf_selout_d = rs2_q;
            end
            RD_B:    op_b_d = cap_data;
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready_q <= 1'b0;
            op_valid_q  <= 1'b0;
            rf_read_q   <= 1'b0;
            rf_en_q     <= 1'b0;
            rf_selout_q <= '0;
            rs2_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            req_ready_q <= req_ready_d;
            op_valid_q  <= op_valid_d;
            rf_read_q   <= rf_read_d;
            rf_en_q     <= 1'b1;
            rf_selout_q <= rf_selout_d;
            rs2_q       <= rs2_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
        end
    end

    assign fetch.req_ready = req_ready_q;
    assign fetch.op_valid  = op_valid_q;
    assign fetch.op_a      = op_a_q;
    assign fetch.op_b      = op_b_q;
    assign rf_en           = rf_en_q;
    assign rf_read         = rf_read_q;
    assign rf_selout       = rf_selout_q;

    // Write-back goes straight through; reset forces the write port quiet
    assign rf_write = reset && fetch.wb_valid && !(ZERO_REG && (fetch.wb_addr == '0));
    assign rf_selin = reset ? fetch.wb_addr : '0;
    assign rf_inp   = reset ? fetch.wb_data : '0;
endmodule
